key_debounce: RTL
=================

Name: key_debounce

Overview:
- Front-end conditioning stage for the push-buttons (add, sub, stop, mode) that drive the clock/time-set and seven-segment display block.
- Synchronises the raw active-low key inputs, debounces each key with a stability counter, and issues one-cycle active-low press pulses. The consumer can sample these pulses directly on its clock.
- Selected keys (add/sub) auto-repeat while held, so time-set fields can be scrolled.
- Bit mapping: bit0 add, bit1 sub, bit2 stop, bit3 mode.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEB_CYCLES, 20000, consecutive clk cycles a synchronised level must differ from the debounced level before it is accepted (>=2).
- REPEAT_DELAY, 500000, cycles from a press pulse to the first auto-repeat pulse (>=2).
- REPEAT_RATE, 100000, cycles between successive auto-repeat pulses (>=1).
- REPEAT_MASK, 4'b0011, per-key enable for auto-repeat (1 = repeats).

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- res, input, 1, reset; synchronous, active-high.
- key_n, input, N_KEYS, raw asynchronous buttons; 0 = pressed.
- key_lvl_n, output, N_KEYS, debounced level; 0 = pressed.
- key_pulse_n, output, N_KEYS, one-cycle low strobe per accepted press and per auto-repeat; otherwise 1.
- key_hold, output, N_KEYS, 1 while a key is in the repeating state.

Behaviour:
- Reset: res=1 at a rising edge has the following effects on the next state:
  - synchroniser flops = 1;
  - key_lvl_n = all 1, key_pulse_n = all 1, key_hold = 0;
  - all counters = 0;
  - all FSMs = IDLE.
- Reset dominates every other event, including mid-debounce and mid-repeat.
- A key held through reset is treated as a new press after res falls. It produces one pulse after the normal debounce latency.
- Synchroniser: two flops per key (sync1, sync2). Only sync2 is used downstream.
- Debounce, per key:
  - Counter width is $clog2(DEB_CYCLES).
  - If sync2 == key_lvl_n, the counter clears.
  - If they differ and counter < DEB_CYCLES-1, the counter increments.
  - If they differ and counter == DEB_CYCLES-1, key_lvl_n takes sync2 and the counter clears.
  - Any bounce back to the stable value restarts the count.
  - Latency: a clean raw edge changes key_lvl_n on the (2+DEB_CYCLES)-th rising edge after the edge that first samples it.
- Press pulse:
  - On the edge where key_lvl_n goes 1->0, key_pulse_n goes low for exactly one cycle, aligned with that key_lvl_n transition.
  - A release (0->1) never pulses.
- Per-key FSM (repeat counter width covers max(REPEAT_DELAY, REPEAT_RATE)):
  - IDLE: on a debounced press, emit a pulse, clear the repeat counter, and go to WAIT.
  - WAIT: if the key is released, go to IDLE. Otherwise, when REPEAT_MASK bit = 1 and the counter reaches REPEAT_DELAY-1, emit a pulse, clear the counter, and go to REPEAT. Masked-off keys stay in WAIT with no further pulses.
  - REPEAT: key_hold = 1. When the counter reaches REPEAT_RATE-1, emit a pulse and clear the counter. On release, go to IDLE with key_hold = 0 on the same edge.
- Pulse timing: with the press pulse at edge T, repeats occur at T+REPEAT_DELAY, then T+REPEAT_DELAY+k*REPEAT_RATE.
- Release coinciding with a repeat instant: release wins and no pulse is emitted.
- Channels are fully independent. Simultaneous presses on several keys pulse in the same cycle, with no arbitration or priority.
- No combinational path from key_n to any output. All outputs are registered.

Test Plan:
- Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset: drive res=1 for 2 cycles with key_n=4'b0000 -> during reset key_lvl_n=4'hF, key_pulse_n=4'hF, key_hold=0. After res falls, all four keys pulse together exactly at edge 6, then key_lvl_n=4'h0.
- Bounce rejection: toggle key_n[3] 1/0 every 2 cycles for 40 cycles, then hold it at 1 -> key_lvl_n[3] stays 1 and no pulse on key_pulse_n[3].
- Clean press of mode (key_n[3] 1->0 sampled at edge 0, held for 8 cycles, then released) -> one low pulse at edge 6 with key_lvl_n[3]=0 from edge 6. key_lvl_n[3] returns to 1 six edges after the release is sampled, with no pulse on release. key_hold[3] stays 0.
- Auto-repeat on add (key_n[0] held low for 30 cycles) -> key_pulse_n[0] low at edges 6, 16, 19, 22, 25, 28, 31, 34. key_hold[0]=1 from edge 16 until the debounced release. No pulse at the release edge.
- Non-repeat key: hold stop (key_n[2]) low for 30 cycles -> exactly one pulse at edge 6 and key_hold[2] stays 0.
- Simultaneous events:
  - Press sub and mode on the same cycle -> both pulse at edge 6.
  - Assert res for 1 cycle during sub's REPEAT state -> all outputs return to reset values on the next edge. With sub still held, a fresh pulse follows 6 edges after res falls.

Source files
------------

// File: rtl/key_debounce_if.sv
// Key bundle between the raw push-buttons and the debounce stage.
// master drives the raw keys; slave (the debouncer) returns conditioned levels and strobes.
interface key_debounce_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_lvl_n;
    logic [N_KEYS-1:0] key_pulse_n;
    logic [N_KEYS-1:0] key_hold;

    modport master (
        output key_n,
        input  key_lvl_n,
        input  key_pulse_n,
        input  key_hold
    );

    modport slave (
        input  key_n,
        output key_lvl_n,
        output key_pulse_n,
        output key_hold
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop sync, per-key stability-counter debounce,
// one-cycle active-low press strobes and masked auto-repeat while held.
module key_debounce #(
    parameter int unsigned       N_KEYS       = 4,
    parameter int unsigned       DEB_CYCLES   = 20000,
    parameter int unsigned       REPEAT_DELAY = 500000,
    parameter int unsigned       REPEAT_RATE  = 100000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK  = N_KEYS'(4'b0011)
) (
    input  logic               clk,
    input  logic               res,
    key_debounce_if.slave      keys
);
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REPEAT
    } state_t;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    // Debounced level; key_lvl_n is its registered copy so level and strobe change together.
    logic [N_KEYS-1:0] lvl_q;
    logic [N_KEYS-1:0] lvl_d;
    logic [DEB_W-1:0]  deb_cnt_q [N_KEYS];
    logic [DEB_W-1:0]  deb_cnt_d [N_KEYS];

    state_t            state_q   [N_KEYS];
    state_t            state_d   [N_KEYS];
    logic [RPT_W-1:0]  rpt_cnt_q [N_KEYS];
    logic [RPT_W-1:0]  rpt_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] pulse_d;
    logic [N_KEYS-1:0] hold_d;

    // State register; reset dominates every other event.
    always_ff @(posedge clk) begin
        if (res) begin
            sync1_q          <= '1;
            sync2_q          <= '1;
            lvl_q            <= '1;
            keys.key_lvl_n   <= '1;
            keys.key_pulse_n <= '1;
            keys.key_hold    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt_q[i] <= '0;
                rpt_cnt_q[i] <= '0;
                state_q[i]   <= ST_IDLE;
            end
        end else begin
            sync1_q          <= keys.key_n;
            sync2_q          <= sync1_q;
            lvl_q            <= lvl_d;
            keys.key_lvl_n   <= lvl_q;
            keys.key_pulse_n <= pulse_d;
            keys.key_hold    <= hold_d;
            deb_cnt_q        <= deb_cnt_d;
            rpt_cnt_q        <= rpt_cnt_d;
            state_q          <= state_d;
        end
    end

    // Per-key debounce counter and press/repeat FSM next-state logic.
    always_comb begin
        lvl_d     = lvl_q;
        pulse_d   = '1;
        hold_d    = '0;
        deb_cnt_d = deb_cnt_q;
        rpt_cnt_d = rpt_cnt_q;
        state_d   = state_q;

        for (int i = 0; i < N_KEYS; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end

            case (state_q[i])
                ST_IDLE: begin
                    if (!lvl_q[i]) begin
                        pulse_d[i]   = 1'b0;
                        rpt_cnt_d[i] = '0;
                        state_d[i]   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lvl_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (REPEAT_MASK[i]) begin
                        if (rpt_cnt_q[i] == DELAY_LAST) begin
                            pulse_d[i]   = 1'b0;
                            hold_d[i]    = 1'b1;
                            rpt_cnt_d[i] = '0;
                            state_d[i]   = ST_REPEAT;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    // Release wins over a coinciding repeat instant.
                    if (lvl_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        hold_d[i] = 1'b1;
                        if (rpt_cnt_q[i] == RATE_LAST) begin
                            pulse_d[i]   = 1'b0;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                        end
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end
endmodule
